// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - timed demand-driven phase scheduler for a two-street crossing with pedestrian phase
module intersection_phase_scheduler #(
  parameter int G_MIN      = 6,
  parameter int G_MAX      = 20,
  parameter int Y_TIME     = 2,
  parameter int AR_TIME    = 1,
  parameter int WALK_TIME  = 8,
  parameter int FLASH_TIME = 4,
  parameter int CW         = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Sa,
  input  logic       Sb,
  input  logic       ped_btn,
  output logic       Ga,
  output logic       Ya,
  output logic       Ra,
  output logic       Gb,
  output logic       Yb,
  output logic       Rb,
  output logic       walk,
  output logic       walk_flash,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    A_RED  = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    B_RED  = 3'd5,
    P_WALK = 3'd6,
    P_FLSH = 3'd7
  } state_t;

  // Street selector used after a pedestrian phase.
  localparam logic ST_A = 1'b0;
  localparam logic ST_B = 1'b1;

  // Terminal timer counts: a phase of D cycles ends when the timer reads D-1.
  localparam logic [CW-1:0] L_GMIN_END  = CW'(G_MIN - 1);
  localparam logic [CW-1:0] L_GMAX_END  = CW'(G_MAX - 1);
  localparam logic [CW-1:0] L_Y_END     = CW'(Y_TIME - 1);
  localparam logic [CW-1:0] L_AR_END    = CW'(AR_TIME - 1);
  localparam logic [CW-1:0] L_WALK_END  = CW'(WALK_TIME - 1);
  localparam logic [CW-1:0] L_FLASH_END = CW'(FLASH_TIME - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_timer;
  logic            r_ped_pending;
  logic            r_next_street;
  logic            w_next_street_nxt;

  logic            w_green;
  logic            w_min_done;
  logic            w_max_done;
  logic            w_a_exit;
  logic            w_b_exit;

  assign w_green    = (r_state == A_GRN) || (r_state == B_GRN);
  assign w_min_done = (r_timer >= L_GMIN_END);
  assign w_max_done = (r_timer == L_GMAX_END);

  // A green ends only when someone else is waiting; it may end early once
  // its own street has gone quiet, otherwise it runs to the max-green limit.
  assign w_a_exit = w_min_done && (Sb || r_ped_pending) && (!Sa || w_max_done);
  assign w_b_exit = w_min_done && (Sa || r_ped_pending) && (!Sb || w_max_done);

  // Next-state selection and bookkeeping of which street follows a walk phase.
  always_comb begin
    w_state_nxt       = r_state;
    w_next_street_nxt = r_next_street;
    case (r_state)
      A_GRN: begin
        if (w_a_exit) w_state_nxt = A_YEL;
      end
      A_YEL: begin
        if (r_timer == L_Y_END) w_state_nxt = A_RED;
      end
      A_RED: begin
        if (r_timer == L_AR_END) begin
          w_state_nxt       = r_ped_pending ? P_WALK : B_GRN;
          w_next_street_nxt = ST_B;
        end
      end
      B_GRN: begin
        if (w_b_exit) w_state_nxt = B_YEL;
      end
      B_YEL: begin
        if (r_timer == L_Y_END) w_state_nxt = B_RED;
      end
      B_RED: begin
        if (r_timer == L_AR_END) begin
          w_state_nxt       = r_ped_pending ? P_WALK : A_GRN;
          w_next_street_nxt = ST_A;
        end
      end
      P_WALK: begin
        if (r_timer == L_WALK_END) w_state_nxt = P_FLSH;
      end
      P_FLSH: begin
        if (r_timer == L_FLASH_END) begin
          w_state_nxt = (r_next_street == ST_A) ? A_GRN : B_GRN;
        end
      end
      default: begin
        w_state_nxt = A_GRN;
      end
    endcase
  end

  // State, phase timer, pedestrian latch and street selector registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= A_GRN;
      r_timer       <= '0;
      r_ped_pending <= 1'b0;
      r_next_street <= ST_B;
    end else begin
      r_state       <= w_state_nxt;
      r_next_street <= w_next_street_nxt;

      // Greens hold the timer at the max-green count so a resting green
      // can still be measured against both limits when demand appears.
      if (w_state_nxt != r_state) begin
        r_timer <= '0;
      end else if (w_green && w_max_done) begin
        r_timer <= r_timer;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      // The walk phase serves the request; presses during it are dropped,
      // while a press in the flashing phase queues another walk.
      if (r_state == P_WALK) begin
        r_ped_pending <= 1'b0;
      end else if (ped_btn) begin
        r_ped_pending <= 1'b1;
      end
    end
  end

  // Moore lamp decode from the current phase.
  always_comb begin
    Ga         = 1'b0;
    Ya         = 1'b0;
    Ra         = 1'b0;
    Gb         = 1'b0;
    Yb         = 1'b0;
    Rb         = 1'b0;
    walk       = 1'b0;
    walk_flash = 1'b0;
    case (r_state)
      A_GRN: begin
        Ga = 1'b1;
        Rb = 1'b1;
      end
      A_YEL: begin
        Ya = 1'b1;
        Rb = 1'b1;
      end
      B_GRN: begin
        Ra = 1'b1;
        Gb = 1'b1;
      end
      B_YEL: begin
        Ra = 1'b1;
        Yb = 1'b1;
      end
      P_WALK: begin
        Ra   = 1'b1;
        Rb   = 1'b1;
        walk = 1'b1;
      end
      P_FLSH: begin
        Ra         = 1'b1;
        Rb         = 1'b1;
        walk_flash = 1'b1;
      end
      default: begin
        Ra = 1'b1;
        Rb = 1'b1;
      end
    endcase
  end

  assign phase       = r_state;
  assign ped_pending = r_ped_pending;

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Timed, demand-driven phase scheduler for a two-street intersection with a pedestrian crossing.
- Shares the intersection between three requesters: street A sensor, street B sensor, and the latched pedestrian button.
- Enforces minimum green, maximum green, yellow, all-red and walk/flash durations with a single phase timer.
- Drives the lamp outputs directly; sits between the sensor/button synchronisers and the lamp drivers.

Parameters:
- G_MIN, 6, minimum green cycles per street phase.
- G_MAX, 20, maximum green cycles when competing demand exists.
- Y_TIME, 2, yellow cycles.
- AR_TIME, 1, all-red clearance cycles.
- WALK_TIME, 8, pedestrian walk cycles.
- FLASH_TIME, 4, pedestrian flashing-don't-walk cycles.
- CW, 5, phase timer width.
- Legal values: all durations >=1, G_MIN <= G_MAX, every duration <= 2^CW.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Sa  in  1  street A vehicle demand (level).
- Sb  in  1  street B vehicle demand (level).
- ped_btn  in  1  pedestrian request (pulse or level).
- Ga, Ya, Ra  out  1 each  street A lamps.
- Gb, Yb, Rb  out  1 each  street B lamps.
- walk  out  1  pedestrian walk lamp.
- walk_flash  out  1  flashing don't-walk indicator.
- ped_pending  out  1  latched, unserved pedestrian request.
- phase  out  3  current state encoding.

Behaviour:
- Single clock, one clock domain.
- reset is synchronous and active-high.
- Phase encoding:
  - A_GRN=0, A_YEL=1, A_RED=2
  - B_GRN=3, B_YEL=4, B_RED=5
  - P_WALK=6, P_FLSH=7
- All 8 codes are legal.
- Registers: state, timer[CW-1:0], ped_pending, next_street (0=A, 1=B).
- Reset (rising clk with reset=1): state=A_GRN, timer=0, ped_pending=0, next_street=B.
- Reset wins over every other event, including in mid-phase.
- Outputs are Moore, decoded combinationally from state:
  - A_GRN: Ga, Rb
  - A_YEL: Ya, Rb
  - A_RED, B_RED, P_WALK, P_FLSH: Ra, Rb
  - B_GRN: Ra, Gb
  - B_YEL: Ra, Yb
  - P_WALK: walk=1
  - P_FLSH: walk_flash=1
  - All other outputs are 0.
- Reset output values: Ga=1, Rb=1, phase=0, all others 0.
- Timer: clears to 0 on every state change; otherwise increments; saturates at G_MAX-1 in green states.
- Green exit, A_GRN -> A_YEL when all of:
  - timer >= G_MIN-1
  - competing demand (Sb | ped_pending)
  - (~Sa | timer == G_MAX-1)
- B_GRN -> B_YEL: same rule, with competing demand (Sa | ped_pending) and own demand Sb.
- With no competing demand, green rests indefinitely; there is no max-out.
- A_YEL -> A_RED and B_YEL -> B_RED at timer == Y_TIME-1.
- A_RED exit at timer == AR_TIME-1:
  - go to P_WALK if ped_pending, else B_GRN
  - set next_street=B
- B_RED exit: same rule, to P_WALK or A_GRN; set next_street=A.
- P_WALK -> P_FLSH at timer == WALK_TIME-1.
- P_FLSH exit at timer == FLASH_TIME-1: go to A_GRN if next_street==A, else B_GRN.
- ped_pending:
  - set when ped_btn=1 and state != P_WALK
  - cleared every cycle that state == P_WALK
  - a press during P_WALK is ignored
  - a press during P_FLSH is retained for the next cycle
- Sa/Sb are sampled every cycle; no latching.
- At most one green or walk is active at any time; the bench asserts this as an invariant.

Test Plan:
- Reset, then Sa=Sb=ped_btn=0 for 50 cycles -> phase stays 0, Ga=Rb=1, timer saturates at 19.
- Reset, then Sb=1, Sa=0 -> cycles 0-5 A_GRN, 6-7 A_YEL, 8 A_RED, cycle 9 B_GRN with Gb=Ra=1.
- Sa=Sb=1 held -> A_GRN 20 cycles, A_YEL 2, A_RED 1, B_GRN 20, B_YEL 2, B_RED 1, repeating with period 46.
- Sa=Sb=0, one-cycle ped_btn at A_GRN timer=2 -> ped_pending=1, then:
  - A_YEL at cycle 6, A_RED at cycle 8
  - P_WALK cycles 9-16 with walk=1; ped_pending=0 from cycle 10
  - P_FLSH cycles 17-20 with walk_flash=1
  - B_GRN at cycle 21
- ped_btn pulse in P_WALK -> no effect. ped_btn pulse in P_FLSH -> after B_GRN 6 cycles, B_YEL, B_RED, then P_WALK again.
- reset=1 for one cycle during B_YEL -> next cycle phase=0, Ga=Rb=1, timer=0, ped_pending=0.
